// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver and its receive FIFO.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    typedef struct packed {
        logic       perr;
        logic       ferr;
        logic [7:0] data;
    } rx_entry_t;

    localparam int DATA_LEN_BASE = 5;

endpackage

// File: rtl/rx_sync_fifo.sv
// First-word fall-through synchronous FIFO; the head reads as zero while empty.
module rx_sync_fifo #(
    parameter int  DEPTH   = 8,
    parameter type entry_t = logic [9:0],
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  entry_t        wdata,
    input  logic          pop,
    output entry_t        rdata,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow
);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     cnt;
    logic            do_pop;
    logic            do_push;

    assign empty    = (cnt == '0);
    assign full     = (cnt == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && full && !do_pop;
    assign count    = cnt;
    assign rdata    = empty ? entry_t'(0) : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (5-8 data bits, optional parity, 1/2 stop bits) feeding a tagged receive FIFO.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int BRD_W      = 16,
    localparam int CW        = $clog2(FIFO_DEPTH) + 1,
    localparam int OS_W      = $clog2(OVERSAMPLE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_in,
    input  logic [BRD_W-1:0] brd,
    input  logic [1:0]       data_len,
    input  logic             parity_en,
    input  logic             parity_odd,
    input  logic             two_stop,
    input  logic             get,
    input  logic             err_clr,
    output logic [7:0]       rx_data,
    output logic             rx_perr,
    output logic             rx_ferr,
    output logic             rx_valid,
    output logic             rx_full,
    output logic [CW-1:0]    fifo_count,
    output logic             overrun_err,
    output logic             busy
);

    rx_state_e        state, state_next;
    logic             rx_s1, rx_s2, rx_d;
    logic [BRD_W-1:0] brd_eff, tick_cnt;
    logic             tick, start_det, sample_pt, push, overflow, empty;
    logic [OS_W-1:0]  os_cnt;
    logic [2:0]       bit_cnt, last_bit;
    logic [7:0]       shift_reg;
    logic [1:0]       len_q;
    logic             par_en_q, par_odd_q, two_stop_q, perr_q, ferr_q;
    rx_entry_t        wr_entry, head;

    assign brd_eff   = (brd == '0) ? BRD_W'(1) : brd;
    assign tick      = (tick_cnt >= brd_eff - BRD_W'(1));
    assign start_det = (state == IDLE) && rx_d && !rx_s2;
    assign last_bit  = {1'b0, len_q} + 3'(DATA_LEN_BASE - 1);
    // START samples half a bit in; every later sample is a full bit apart.
    assign sample_pt = tick && ((state == START) ? (os_cnt == OS_W'(OVERSAMPLE/2 - 1))
                                                 : (os_cnt == OS_W'(OVERSAMPLE - 1)));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        push       = 1'b0;
        case (state)
            IDLE:    if (start_det) state_next = START;
            START:   if (sample_pt) state_next = rx_s2 ? IDLE : DATA;
            DATA:    if (sample_pt && bit_cnt == last_bit)
                         state_next = par_en_q ? PARITY : STOP;
            PARITY:  if (sample_pt) state_next = STOP;
            STOP:    if (sample_pt && (!two_stop_q || bit_cnt[0])) begin
                         push       = 1'b1;
                         state_next = IDLE;
                     end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1       <= 1'b1;
            rx_s2       <= 1'b1;
            rx_d        <= 1'b1;
            tick_cnt    <= '0;
            os_cnt      <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            len_q       <= '0;
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            two_stop_q  <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            rx_s1 <= rx_in;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
            tick_cnt <= (start_det || tick) ? '0 : tick_cnt + BRD_W'(1);

            if (start_det) begin
                len_q      <= data_len;
                par_en_q   <= parity_en;
                par_odd_q  <= parity_odd;
                two_stop_q <= two_stop;
                shift_reg  <= '0;
                perr_q     <= 1'b0;
                ferr_q     <= 1'b0;
            end

            if (state == IDLE || sample_pt) os_cnt <= '0;
            else if (tick)                  os_cnt <= os_cnt + OS_W'(1);

            if (state != state_next) bit_cnt <= '0;
            else if (sample_pt)      bit_cnt <= bit_cnt + 3'd1;

            if (sample_pt) begin
                case (state)
                    DATA:    shift_reg[bit_cnt] <= rx_s2;
                    PARITY:  perr_q <= (^shift_reg) ^ rx_s2 ^ par_odd_q;
                    STOP:    if (!rx_s2) ferr_q <= 1'b1;
                    default: ;
                endcase
            end

            if (overflow)     overrun_err <= 1'b1;
            else if (err_clr) overrun_err <= 1'b0;
        end
    end

    always_comb begin
        wr_entry      = '0;
        wr_entry.perr = perr_q;
        wr_entry.ferr = ferr_q | !rx_s2;
        wr_entry.data = shift_reg;
    end

    rx_sync_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (rx_entry_t)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .wdata    (wr_entry),
        .pop      (get),
        .rdata    (head),
        .empty    (empty),
        .full     (rx_full),
        .count    (fifo_count),
        .overflow (overflow)
    );

    assign rx_data  = head.data;
    assign rx_perr  = head.perr;
    assign rx_ferr  = head.ferr;
    assign rx_valid = !empty;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized frames checked against a queue-based model of the receive FIFO.
module tb_uart_rx_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_in;
    logic [15:0] brd;
    logic [1:0]  data_len;
    logic        parity_en, parity_odd, two_stop, get, err_clr;
    logic [7:0]  rx_data;
    logic        rx_perr, rx_ferr, rx_valid, rx_full, overrun_err, busy;
    logic [3:0]  fifo_count;

    int          checks = 0;
    int          errors = 0;
    logic [9:0]  exp_q[$];
    bit          exp_ovr = 1'b0;

    uart_rx_fifo #(.OVERSAMPLE(16), .FIFO_DEPTH(8), .BRD_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .brd         (brd),
        .data_len    (data_len),
        .parity_en   (parity_en),
        .parity_odd  (parity_odd),
        .two_stop    (two_stop),
        .get         (get),
        .err_clr     (err_clr),
        .rx_data     (rx_data),
        .rx_perr     (rx_perr),
        .rx_ferr     (rx_ferr),
        .rx_valid    (rx_valid),
        .rx_full     (rx_full),
        .fifo_count  (fifo_count),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_bits(input int n);
        int per;
        per = ((brd == 0) ? 1 : int'(brd)) * 16;
        repeat (n * per) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input bit pe, input bit po,
                              input bit ts, input bit flip, input bit bad_stop);
        logic [7:0] mask, dm;
        logic       p;
        mask       = 8'((16'd1 << nb) - 16'd1);
        dm         = d & mask;
        data_len   = 2'(nb - 5);
        parity_en  = pe;
        parity_odd = po;
        two_stop   = ts;
        rx_in = 1'b0;
        wait_bits(1);
        data_len   = 2'($urandom);
        parity_en  = 1'($urandom);
        parity_odd = 1'($urandom);
        two_stop   = 1'($urandom);
        for (int i = 0; i < nb; i++) begin
            rx_in = dm[i];
            wait_bits(1);
        end
        p = (^dm) ^ po ^ flip;
        if (pe) begin
            rx_in = p;
            wait_bits(1);
        end
        rx_in = !bad_stop;
        wait_bits(1);
        if (ts) begin
            rx_in = 1'b1;
            wait_bits(1);
        end
        rx_in = 1'b1;
        wait_bits(1);
        if (exp_q.size() < 8) exp_q.push_back({pe && (((^dm) ^ p) != po), bad_stop, dm});
        else                  exp_ovr = 1'b1;
    endtask

    task automatic check_head();
        @(negedge clk);
        check("valid", rx_valid, exp_q.size() > 0);
        check("count", fifo_count, exp_q.size());
        check("full", rx_full, exp_q.size() == 8);
        check("overrun", overrun_err, exp_ovr);
        if (exp_q.size() > 0) begin
            check("data", rx_data, exp_q[0][7:0]);
            check("perr", rx_perr, exp_q[0][9]);
            check("ferr", rx_ferr, exp_q[0][8]);
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_get();
        get = 1'b1;
        @(posedge clk); #1;
        get = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic pop_one();
        check_head();
        pulse_get();
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        exp_ovr = 1'b0;
    endtask

    task automatic check_reset_outs(input string tag);
        @(negedge clk);
        check({tag, "_data"}, rx_data, 8'h00);
        check({tag, "_perr"}, rx_perr, 1'b0);
        check({tag, "_ferr"}, rx_ferr, 1'b0);
        check({tag, "_valid"}, rx_valid, 1'b0);
        check({tag, "_full"}, rx_full, 1'b0);
        check({tag, "_count"}, fifo_count, 4'd0);
        check({tag, "_ovr"}, overrun_err, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int k;
        rst = 1'b1; rx_in = 1'b1; brd = 16'd2; data_len = 2'd3;
        parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0; get = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        check_reset_outs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk); #1;

        // 8N1 0xA5, then a pop, then a pop while empty.
        send_frame(8'hA5, 8, 0, 0, 0, 0, 0);
        pop_one();
        check_head();
        pulse_get();
        check_head();

        // 7E2 with good and flipped parity.
        send_frame(8'h35, 7, 1, 0, 1, 0, 0);
        send_frame(8'h35, 7, 1, 0, 1, 1, 0);
        pop_one();
        pop_one();
        check_head();

        // Stop bit driven low.
        send_frame(8'h3C, 8, 0, 0, 0, 0, 1);
        pop_one();

        // Start-bit glitch of 3 ticks, then a clean frame.
        rx_in = 1'b0;
        repeat (6) @(posedge clk); #1;
        rx_in = 1'b1;
        @(negedge clk);
        check("glitch_busy_hi", busy, 1'b1);
        wait_bits(2);
        @(negedge clk);
        check("glitch_busy_lo", busy, 1'b0);
        check_head();
        send_frame(8'h5A, 8, 0, 0, 0, 0, 0);
        pop_one();

        // Fill past capacity.
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 8, 0, 0, 0, 0, 0);
            check_head();
        end
        for (int i = 0; i < 8; i++) pop_one();
        check_head();
        pulse_clr();
        check_head();

        // Randomized formats, divisors and drain patterns.
        for (int f = 0; f < 20; f++) begin
            brd = 16'($urandom_range(0, 3));
            send_frame(8'($urandom), $urandom_range(5, 8), 1'($urandom), 1'($urandom),
                       1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            check_head();
            k = $urandom_range(0, exp_q.size());
            for (int j = 0; j < k; j++) pop_one();
            if (exp_ovr && $urandom_range(0, 1) == 1) pulse_clr();
            check_head();
        end

        // Reset in the middle of a frame with data buffered.
        brd = 16'd2;
        send_frame(8'hC3, 8, 0, 0, 0, 0, 0);
        check_head();
        data_len = 2'd3; parity_en = 1'b0; two_stop = 1'b0;
        rx_in = 1'b0; wait_bits(1);
        rx_in = 1'b1; wait_bits(1);
        rx_in = 1'b0; wait_bits(1);
        rx_in = 1'b1; wait_bits(1);
        @(negedge clk);
        check("midframe_busy", busy, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        check_reset_outs("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        exp_ovr = 1'b0;
        wait_bits(12);
        check_head();
        send_frame(8'h96, 8, 0, 0, 0, 0, 0);
        pop_one();
        check_head();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
